pwm_sequencer: RTL and testbench

Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Free-running prescaler and 8-bit PWM counter. Configuration is double-buffered: new values from the SPI register bank are captured only at a PWM period boundary, so no output ever shows a truncated or glitched pulse. Sits between the SPI register bank and the output pins.

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_prescaler.sv | 47 ++++
 rtl/pwm_sequencer.sv | 136 +++++++++++++
 tb/tb_pwm_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Definitions shared by the PWM output sequencer and the SPI register bank:
// PWM counter limit, full-duty code, configuration register addresses and the
// per-tick PWM level rule.
// -----------------------------------------------------------------------------
package pwm_pkg;

  // The PWM counter runs 0..PWM_MAX, giving a period of 255 ticks.
  localparam logic [7:0] PWM_MAX   = 8'd254;
  // This duty code means "always high", not "high for 255 of 255 ticks".
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  // Configuration register map, shared with the SPI register bank.
  typedef enum logic [6:0] {
    REG_EN_OUT_7_0  = 7'h00,
    REG_EN_OUT_15_8 = 7'h01,
    REG_EN_PWM_7_0  = 7'h02,
    REG_EN_PWM_15_8 = 7'h03,
    REG_PWM_DUTY    = 7'h04
  } pwm_reg_addr_e;

  // PWM level for a given counter position and duty value.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
    logic lvl;
    if (duty == DUTY_FULL) begin
      lvl = 1'b1;
    end else begin
      lvl = (cnt < duty);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
// Free-running clock divider. Counts 0..CLK_DIV-1 and wraps; tick is high
// during the last count. With CLK_DIV=1 tick is permanently high.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset (counter back to 0)
//   tick  out  one-cycle enable every CLK_DIV clocks
// Parameter:
//   CLK_DIV  clk cycles per tick, 1..65535
// -----------------------------------------------------------------------------
module pwm_prescaler #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 32'd1);

  logic [15:0] div_cnt_q;
  logic [15:0] div_cnt_d;

  assign tick = (div_cnt_q == DIV_LAST);

  // Next divider count: wrap to zero on the tick cycle.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (tick) begin
      div_cnt_d = 16'd0;
    end else begin
      div_cnt_d = div_cnt_q + 16'd1;
    end
  end

  // Divider count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= 16'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_sequencer
// Drives the 16 chip outputs from the SPI configuration registers. An 8-bit
// PWM counter advances once per prescaler tick over a 255-tick period. The
// configuration is double-buffered into shadow (act_*) registers that load
// only at the period wrap, or immediately when every output is disabled, so
// a running pulse is never cut short.
//
// Ports:
//   clk              in   system clock
//   rst              in   synchronous, active-high reset
//   en_reg_out_7_0   in   output enable, outputs 7..0
//   en_reg_out_15_8  in   output enable, outputs 15..8
//   en_reg_pwm_7_0   in   PWM mode select, outputs 7..0
//   en_reg_pwm_15_8  in   PWM mode select, outputs 15..8
//   pwm_duty_cycle   in   shared duty value (0xFF = always high)
//   cfg_valid        in   one-cycle pulse: register inputs changed and stable
//   cfg_pending      out  new config announced but not yet applied
//   period_start     out  one-cycle pulse on the first tick of each period
//   out              out  output pins (registered)
// Parameter:
//   CLK_DIV  clk cycles per PWM tick, 1..65535
// -----------------------------------------------------------------------------
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  input  logic        cfg_valid,
  output logic        cfg_pending,
  output logic        period_start,
  output logic [15:0] out
);

  logic        tick;
  logic        wrap;
  logic        load;
  logic        pwm_lvl;

  logic [7:0]  pwm_cnt_q,      pwm_cnt_d;
  logic [15:0] act_out_q,      act_out_d;
  logic [15:0] act_pwm_q,      act_pwm_d;
  logic [7:0]  act_duty_q,     act_duty_d;
  logic        cfg_pending_q,  cfg_pending_d;
  logic        period_start_q, period_start_d;
  logic [15:0] out_q,          out_d;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state logic for the PWM counter, shadow config, pending flag and pins.
  always_comb begin
    pwm_cnt_d      = pwm_cnt_q;
    act_out_d      = act_out_q;
    act_pwm_d      = act_pwm_q;
    act_duty_d     = act_duty_q;
    cfg_pending_d  = cfg_pending_q;

    wrap = tick && (pwm_cnt_q == PWM_MAX);
    // With every output off nothing visible can glitch, so load right away.
    load = wrap || (cfg_valid && (act_out_q == 16'h0000));

    if (tick) begin
      if (pwm_cnt_q == PWM_MAX) begin
        pwm_cnt_d = 8'd0;
      end else begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
      end
    end else begin
      pwm_cnt_d = pwm_cnt_q;
    end

    // Inputs are sampled at the load cycle, so the latest stable values win.
    if (load) begin
      act_out_d  = {en_reg_out_15_8, en_reg_out_7_0};
      act_pwm_d  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      act_duty_d = pwm_duty_cycle;
    end else begin
      act_out_d  = act_out_q;
      act_pwm_d  = act_pwm_q;
      act_duty_d = act_duty_q;
    end

    // A load in the same cycle as cfg_valid absorbs it: pending stays clear.
    if (load) begin
      cfg_pending_d = 1'b0;
    end else if (cfg_valid) begin
      cfg_pending_d = 1'b1;
    end else begin
      cfg_pending_d = cfg_pending_q;
    end

    pwm_lvl        = pwm_level(pwm_cnt_q, act_duty_q);
    // Enabled pins follow the PWM level in PWM mode, otherwise sit high.
    out_d          = act_out_q & (~act_pwm_q | {16{pwm_lvl}});
    period_start_d = tick && (pwm_cnt_q == 8'd0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q      <= 8'd0;
      act_out_q      <= 16'h0000;
      act_pwm_q      <= 16'h0000;
      act_duty_q     <= 8'd0;
      cfg_pending_q  <= 1'b0;
      period_start_q <= 1'b0;
      out_q          <= 16'h0000;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      act_out_q      <= act_out_d;
      act_pwm_q      <= act_pwm_d;
      act_duty_q     <= act_duty_d;
      cfg_pending_q  <= cfg_pending_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign cfg_pending  = cfg_pending_q;
  assign period_start = period_start_q;
  assign out          = out_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_sequencer
// Two sequencer instances (CLK_DIV=1 and CLK_DIV=10) share one stimulus
// stream. A reference model derives counter position from elapsed cycles
// since reset and checks every output of both instances each cycle, while
// directed scenarios check pulse widths, latencies and pending behaviour.
// -----------------------------------------------------------------------------
module tb_pwm_sequencer;

  localparam int DIV_F = 1;
  localparam int DIV_S = 10;

  logic        clk;
  logic        rst;
  logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic        cfg_valid;

  logic        pend_f, ps_f, pend_s, ps_s;
  logic [15:0] out_f, out_s;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state, index 0 = fast instance, 1 = slow instance.
  int          dv [2];
  int          cyc [2];
  logic [15:0] m_act_out [2];
  logic [15:0] m_act_pwm [2];
  logic [7:0]  m_duty [2];
  logic        m_pend [2];
  logic        m_ps [2];
  logic [15:0] m_out [2];
  logic        armed = 1'b0;

  pwm_sequencer #(.CLK_DIV(DIV_F)) dut_f (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .cfg_valid       (cfg_valid),
    .cfg_pending     (pend_f),
    .period_start    (ps_f),
    .out             (out_f)
  );

  pwm_sequencer #(.CLK_DIV(DIV_S)) dut_s (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .cfg_valid       (cfg_valid),
    .cfg_pending     (pend_s),
    .period_start    (ps_s),
    .out             (out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Pin values from the spec rules for one counter position.
  function automatic logic [15:0] pins(input logic [15:0] ao, input logic [15:0] ap,
                                       input logic [7:0] d, input int p);
    logic        lvl;
    logic [15:0] r;
    lvl = (d == 8'hFF) ? 1'b1 : (p < int'(d));
    for (int i = 0; i < 16; i++) r[i] = ao[i] ? (ap[i] ? lvl : 1'b1) : 1'b0;
    return r;
  endfunction

  // Advance the model of instance k by one clock using the sampled inputs.
  task automatic model_step(input int k);
    int p;
    bit tk;
    bit ld;
    if (rst) begin
      cyc[k] = 0;
      m_act_out[k] = 16'h0; m_act_pwm[k] = 16'h0; m_duty[k] = 8'd0;
      m_pend[k] = 1'b0; m_ps[k] = 1'b0; m_out[k] = 16'h0;
    end else begin
      p  = (cyc[k] / dv[k]) % 255;
      tk = ((cyc[k] % dv[k]) == dv[k] - 1);
      m_out[k] = pins(m_act_out[k], m_act_pwm[k], m_duty[k], p);
      m_ps[k]  = tk && (p == 0);
      ld = (tk && (p == 254)) || (cfg_valid && (m_act_out[k] == 16'h0));
      if (ld) begin
        m_act_out[k] = {en_out_hi, en_out_lo};
        m_act_pwm[k] = {en_pwm_hi, en_pwm_lo};
        m_duty[k]    = duty;
        m_pend[k]    = 1'b0;
      end else if (cfg_valid) begin
        m_pend[k] = 1'b1;
      end
      cyc[k]++;
    end
  endtask

  // One clock: update the model at the edge, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (rst) armed = 1'b1;
    @(negedge clk);
    if (armed) begin
      check_val("out_f",  32'(out_f),  32'(m_out[0]));
      check_val("ps_f",   32'(ps_f),   32'(m_ps[0]));
      check_val("pend_f", 32'(pend_f), 32'(m_pend[0]));
      check_val("out_s",  32'(out_s),  32'(m_out[1]));
      check_val("ps_s",   32'(ps_s),   32'(m_ps[1]));
      check_val("pend_s", 32'(pend_s), 32'(m_pend[1]));
    end
  endtask

  // Counter position the fast / slow instance holds during the next cycle.
  function automatic int pos_f();
    return cyc[0] % 255;
  endfunction

  function automatic int pos_s();
    return (cyc[1] / DIV_S) % 255;
  endfunction

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_out_lo = eo[7:0];  en_out_hi = eo[15:8];
    en_pwm_lo = ep[7:0];  en_pwm_hi = ep[15:8];
    duty      = d;
  endtask

  task automatic pulse_cfg();
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
  endtask

  // Step until the fast instance shows period_start; n = cycles taken.
  task automatic wait_ps_f(output int n, input int budget);
    n = 0;
    do begin
      cycle();
      n++;
    end while (ps_f !== 1'b1 && n < budget);
    if (ps_f !== 1'b1) check_val("ps_f_timeout", 32'(ps_f), 32'd1);
  endtask

  logic [7:0] ext_d  [3] = '{8'd0, 8'hFF, 8'd1};
  int         ext_hi [3] = '{0, 255, 1};

  initial begin
    int n;
    int hi;
    int first_hi;
    int r;
    logic [15:0] eo;

    dv[0] = DIV_F;
    dv[1] = DIV_S;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; m_act_out[k] = 16'h0; m_act_pwm[k] = 16'h0; m_duty[k] = 8'd0;
      m_pend[k] = 1'b0; m_ps[k] = 1'b0; m_out[k] = 16'h0;
    end

    rst = 1'b1;
    cfg_valid = 1'b0;
    set_cfg(16'h0, 16'h0, 8'd0);
    @(negedge clk);
    cycle();
    cycle();
    check_val("rst_out_f", 32'(out_f), 32'h0);
    check_val("rst_out_s", 32'(out_s), 32'h0);
    check_val("rst_pend_f", 32'(pend_f), 32'd0);
    check_val("rst_ps_f", 32'(ps_f), 32'd0);
    rst = 1'b0;

    // Idle outputs, period_start spacing with CLK_DIV=1.
    wait_ps_f(n, 300);
    check_val("ps_first", 32'(n), 32'd1);
    wait_ps_f(n, 300);
    check_val("ps_period1", 32'(n), 32'd255);
    wait_ps_f(n, 300);
    check_val("ps_period2", 32'(n), 32'd255);
    check_val("idle_out", 32'(out_f), 32'h0);

    // Immediate load while every output is disabled.
    set_cfg(16'h0001, 16'h0000, 8'd0);
    pulse_cfg();
    check_val("imm_pend", 32'(pend_f), 32'd0);
    cycle();
    check_val("imm_out", 32'(out_f), 32'h0001);
    check_val("imm_pend2", 32'(pend_f), 32'd0);

    // Full PWM at duty 128, then a mid-period change to 64.
    set_cfg(16'hFFFF, 16'hFFFF, 8'd128);
    pulse_cfg();
    check_val("mid_pend_set", 32'(pend_f), 32'd1);
    wait_ps_f(n, 300);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      hi += int'(out_f[0]);
      if (pos_f() == 10) begin
        duty = 8'd64;
        cfg_valid = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
      cycle();
      if (cfg_valid) check_val("mid_pend", 32'(pend_f), 32'd1);
    end
    cfg_valid = 1'b0;
    check_val("mid_hi_128", 32'(hi), 32'd128);
    check_val("mid_ps_next", 32'(ps_f), 32'd1);
    check_val("mid_pend_clr", 32'(pend_f), 32'd0);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      hi += int'(out_f[0]);
      cycle();
    end
    check_val("mid_hi_64", 32'(hi), 32'd64);

    // Duty extremes on output 5; other enabled outputs stay constant high.
    for (int t = 0; t < 3; t++) begin
      set_cfg(16'hFFFF, 16'h0020, ext_d[t]);
      pulse_cfg();
      wait_ps_f(n, 300);
      check_val("ext_other", 32'(out_f[4]), 32'd1);
      hi = 0;
      first_hi = -1;
      for (int i = 0; i < 255; i++) begin
        if (out_f[5] === 1'b1) begin
          hi++;
          if (first_hi < 0) first_hi = i;
        end
        cycle();
      end
      check_val($sformatf("ext_hi_d%0d", ext_d[t]), 32'(hi), 32'(ext_hi[t]));
      if (ext_d[t] == 8'd1) check_val("duty1_align", 32'(first_hi), 32'd0);
    end

    // cfg_valid in the wrap cycle: loads at once, no pending.
    n = 0;
    while (pos_f() != 254 && n < 300) begin
      cycle();
      n++;
    end
    check_val("wrap_reach", 32'(pos_f()), 32'd254);
    set_cfg(16'hA5A5, 16'h0000, 8'd50);
    pulse_cfg();
    check_val("wrap_pend", 32'(pend_f), 32'd0);
    check_val("wrap_old_out", 32'(out_f), 32'hFFDF);
    cycle();
    check_val("wrap_new_out", 32'(out_f), 32'hA5A5);
    check_val("wrap_ps", 32'(ps_f), 32'd1);

    // Reset while the slow instance has a pending config at pwm_cnt=100.
    n = 0;
    while (pos_s() != 100 && n < 3000) begin
      cycle();
      n++;
    end
    check_val("rst_reach", 32'(pos_s()), 32'd100);
    set_cfg(16'h00FF, 16'h00FF, 8'd200);
    pulse_cfg();
    check_val("rst_pend_before", 32'(pend_s), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("rst2_out_s", 32'(out_s), 32'h0);
    check_val("rst2_pend_s", 32'(pend_s), 32'd0);
    check_val("rst2_ps_s", 32'(ps_s), 32'd0);
    check_val("rst2_out_f", 32'(out_f), 32'h0);
    n = 0;
    do begin
      cycle();
      n++;
    end while (ps_s !== 1'b1 && n < 50);
    check_val("rst_ps_latency", 32'(n), 32'd10);

    // Randomized configuration traffic.
    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 7) begin
        eo = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        case ($urandom_range(0, 4))
          0:       duty = 8'd0;
          1:       duty = 8'd1;
          2:       duty = 8'd254;
          3:       duty = 8'hFF;
          default: duty = 8'($urandom);
        endcase
        set_cfg(eo, 16'($urandom), duty);
      end
      cfg_valid = (r < 4);
      rst = (r == 99) && ($urandom_range(0, 19) == 0);
      cycle();
    end
    cfg_valid = 1'b0;
    rst = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
